// File: rtl/crossyroad_pkg.sv
// Shared definitions for the crossy-road VGA design.
//   SCORE_W   : width of the binary score
//   BCD_W     : width of one BCD digit
//   IDLE/PLAY/OVER : game state encodings (2-bit)
package crossyroad_pkg;

  localparam int unsigned SCORE_W = 7;
  localparam int unsigned BCD_W   = 4;

  typedef logic [1:0] state_t;

  localparam state_t IDLE = 2'd0;
  localparam state_t PLAY = 2'd1;
  localparam state_t OVER = 2'd2;

endpackage

// File: rtl/bcd_digit_counter.sv
// One decimal digit counter, 0..9 with wrap-around and carry out.
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : synchronous clear to 0 (wins over inc)
//   inc        : add one this cycle
//   carry      : inc while the digit is 9 (the digit wraps to 0)
//   digit      : registered BCD digit
module bcd_digit_counter
  import crossyroad_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             inc,
  output logic             carry,
  output logic [BCD_W-1:0] digit
);

  logic [BCD_W-1:0] digit_q, digit_d;
  logic             at_nine;

  assign at_nine = (digit_q == BCD_W'(9));
  assign carry   = inc & at_nine & ~clear;

  always_comb begin
    digit_d = digit_q;
    if (clear) begin
      digit_d = '0;
    end else if (inc) begin
      digit_d = at_nine ? '0 : digit_q + BCD_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit_q <= '0;
    end else begin
      digit_q <= digit_d;
    end
  end

  assign digit = digit_q;

endmodule

// File: rtl/score_keeper.sv
// Score and game-state keeper for the crossy-road VGA design.
// Synchronizes the move button, runs the IDLE/PLAY/OVER state machine, keeps
// a saturating binary score plus a matching BCD digit pair.
//   i_clk, i_rst_n : pixel clock, asynchronous active-low reset
//   i_frame_tick   : one-cycle pulse per frame (drives hold auto-repeat)
//   i_move         : raw move button, asynchronous to i_clk
//   i_collision    : level, player hit an obstacle
//   i_restart      : one-cycle pulse, start a new game
//   o_score        : binary score 0..MAX_SCORE
//   o_score_tens/o_score_ones : BCD digits of o_score
//   o_high_score   : best score since reset (SCORE_KEEPER_HIGH_SCORE_EN),
//                    otherwise constant 0
//   o_game_over    : high while in OVER
// Optional feature macro: SCORE_KEEPER_HIGH_SCORE_EN.
module score_keeper
  import crossyroad_pkg::*;
#(
  parameter int unsigned HOLD_FRAMES = 8,
  parameter int unsigned MAX_SCORE   = 99
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_frame_tick,
  input  logic               i_move,
  input  logic               i_collision,
  input  logic               i_restart,
  output logic [SCORE_W-1:0] o_score,
  output logic [BCD_W-1:0]   o_score_tens,
  output logic [BCD_W-1:0]   o_score_ones,
  output logic [SCORE_W-1:0] o_high_score,
  output logic               o_game_over
);

  // Move button: two-flop synchronizer plus one flop for edge detection.
  logic move_meta, move_s, move_d, move_rise;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      move_meta <= 1'b0;
      move_s    <= 1'b0;
      move_d    <= 1'b0;
    end else begin
      move_meta <= i_move;
      move_s    <= move_meta;
      move_d    <= move_s;
    end
  end

  assign move_rise = move_s & ~move_d;

  state_t             state_q, state_d;
  logic [7:0]         hold_q, hold_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic               game_over_q;
  logic               bump, hold_wrap, inc_en, bcd_clear;
  logic               ones_carry, unused_tens_carry;

  assign hold_wrap = move_s & i_frame_tick & ((hold_q + 8'd1) == 8'(HOLD_FRAMES));

  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    bump      = 1'b0;
    bcd_clear = 1'b0;
    if (i_restart) begin
      state_d   = PLAY;
      hold_d    = '0;
      bcd_clear = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          hold_d = '0;
          // The press that starts the game does not score.
          if (move_rise) state_d = PLAY;
        end
        PLAY: begin
          if (i_collision) begin
            // Collision beats any increment in the same cycle.
            state_d = OVER;
            hold_d  = '0;
          end else begin
            if (!move_s || move_rise) begin
              hold_d = '0;
            end else if (i_frame_tick) begin
              hold_d = hold_wrap ? '0 : hold_q + 8'd1;
            end
            bump = move_rise | hold_wrap;
          end
        end
        OVER: hold_d = '0;
        default: begin
          state_d   = IDLE;
          hold_d    = '0;
          bcd_clear = 1'b1;
        end
      endcase
    end
  end

  // Saturation is applied here so the BCD counters only ever see legal steps.
  assign inc_en = bump & (score_q < SCORE_W'(MAX_SCORE));

  always_comb begin
    score_d = score_q;
    if (bcd_clear) begin
      score_d = '0;
    end else if (inc_en) begin
      score_d = score_q + SCORE_W'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= IDLE;
      hold_q      <= '0;
      score_q     <= '0;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      score_q     <= score_d;
      game_over_q <= (state_d == OVER);
    end
  end

  bcd_digit_counter u_ones (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .clear (bcd_clear),
    .inc   (inc_en),
    .carry (ones_carry),
    .digit (o_score_ones)
  );

  // Score never exceeds 99, so the tens carry is never used.
  bcd_digit_counter u_tens (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .clear (bcd_clear),
    .inc   (ones_carry),
    .carry (unused_tens_carry),
    .digit (o_score_tens)
  );

`ifdef SCORE_KEEPER_HIGH_SCORE_EN
  // Cleared only by reset; survives restart.
  logic [SCORE_W-1:0] high_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      high_q <= '0;
    end else if (score_q > high_q) begin
      high_q <= score_q;
    end
  end

  assign o_high_score = high_q;
`else
  assign o_high_score = '0;
`endif

  assign o_score     = score_q;
  assign o_game_over = game_over_q;

endmodule

// File: tb/tb_score_keeper.sv
// Self-checking bench for score_keeper: a table of per-clock stimulus rows with
// hand-derived expected outputs, plus a hand-written asynchronous reset sequence.
module tb_score_keeper;

`ifdef SCORE_KEEPER_HIGH_SCORE_EN
  localparam bit HighEn = 1'b1;
`else
  localparam bit HighEn = 1'b0;
`endif
  localparam int unsigned MaxScore = 99;

  logic       clk = 1'b0;
  logic       rst_n, tick, move, collision, restart;
  logic [6:0] score, high;
  logic [3:0] tens, ones;
  logic       over;

  always #5 clk = ~clk;

  score_keeper #(
    .HOLD_FRAMES (8),
    .MAX_SCORE   (99)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_frame_tick (tick),
    .i_move       (move),
    .i_collision  (collision),
    .i_restart    (restart),
    .o_score      (score),
    .o_score_tens (tens),
    .o_score_ones (ones),
    .o_high_score (high),
    .o_game_over  (over)
  );

  typedef struct {
    logic        move;
    logic        tick;
    logic        col;
    logic        rst;
    int unsigned score;
    logic        over;
    int unsigned high;
  } vec_t;

  vec_t        vecs[$];
  int unsigned cur;
  int unsigned last_score;
  int unsigned model_high;
  int          n_vec;
  int          n_bad;

  function automatic vec_t mk(input logic mv, input logic tk, input logic cl, input logic rs,
                              input int unsigned sc, input logic ov, input int unsigned hi);
    vec_t v;
    v.move  = mv;
    v.tick  = tk;
    v.col   = cl;
    v.rst   = rs;
    v.score = sc;
    v.over  = ov;
    v.high  = hi;
    return v;
  endfunction

  // High score lags the score by one clock: it is the max of all earlier rows.
  task automatic add(input logic mv, input logic tk, input logic cl, input logic rs,
                     input int unsigned sc, input logic ov);
    if (last_score > model_high) model_high = last_score;
    vecs.push_back(mk(mv, tk, cl, rs, sc, ov, HighEn ? model_high : 0));
    last_score = sc;
  endtask

  // One discrete press: move high two clocks, low two clocks; the rising edge
  // reaches the score on the third clock.
  task automatic add_press(input logic tk, input logic ov);
    int unsigned nxt;
    nxt = ov ? cur : ((cur + 1 > MaxScore) ? MaxScore : cur + 1);
    add(1'b1, tk, 1'b0, 1'b0, cur, ov);
    add(1'b1, tk, 1'b0, 1'b0, cur, ov);
    add(1'b0, tk, 1'b0, 1'b0, nxt, ov);
    add(1'b0, tk, 1'b0, 1'b0, nxt, ov);
    cur = nxt;
  endtask

  task automatic check(input vec_t v, input string name);
    logic [6:0] es, eh;
    logic [3:0] et, eo;
    es = 7'(v.score);
    eh = 7'(v.high);
    et = 4'(v.score / 10);
    eo = 4'(v.score % 10);
    n_vec++;
    if (score !== es || tens !== et || ones !== eo || over !== v.over || high !== eh) begin
      n_bad++;
      $display("FAIL %s: got score=%0d tens=%0d ones=%0d over=%0b high=%0d, want score=%0d tens=%0d ones=%0d over=%0b high=%0d",
               name, score, tens, ones, over, high, es, et, eo, v.over, eh);
    end
  endtask

  task automatic run_row(input vec_t v, input bit chk, input string name);
    move      = v.move;
    tick      = v.tick;
    collision = v.col;
    restart   = v.rst;
    @(posedge clk);
    #1;
    if (chk) check(v, name);
  endtask

  initial begin
    n_vec      = 0;
    n_bad      = 0;
    cur        = 0;
    last_score = 0;
    model_high = 0;
    rst_n      = 1'b0;
    move       = 1'b0;
    tick       = 1'b0;
    collision  = 1'b0;
    restart    = 1'b0;

    // Hold from IDLE: three clocks with no score, then 8 ticks give 1.
    repeat (3) add(1, 0, 0, 0, 0, 0);
    repeat (7) add(1, 1, 0, 0, 0, 0);
    add(1, 1, 0, 0, 1, 0);
    cur = 1;
    add(0, 0, 0, 0, 1, 0);
    add(0, 0, 0, 0, 1, 0);
    add(0, 0, 0, 1, 0, 0);
    cur = 0;
    // Discrete presses up to 42 (covers 5 and the 9->10 carry).
    repeat (42) add_press(0, 0);
    add(0, 0, 1, 0, 42, 1);
    // In OVER, presses and ticks are ignored.
    repeat (2) add_press(1, 1);
    add(0, 0, 0, 1, 0, 0);
    cur = 0;
    // Up to 99 and two presses beyond: saturates at 99, BCD 9/9.
    repeat (101) add_press(0, 0);
    add(0, 0, 0, 1, 0, 0);
    cur = 0;
    // Hold in PLAY: rise scores 1, collision on the 8th tick blocks the increment.
    add(1, 0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 1, 0);
    cur = 1;
    repeat (7) add(1, 1, 0, 0, 1, 0);
    add(1, 1, 1, 0, 1, 1);
    add(0, 0, 0, 0, 1, 1);
    add(0, 0, 0, 0, 1, 1);
    repeat (2) add_press(1, 1);
    // Restart wins over collision; the next press scores, so the state is PLAY.
    add(0, 0, 1, 1, 0, 0);
    cur = 0;
    add_press(0, 0);

    @(posedge clk);
    @(posedge clk);
    #1;
    check(mk(0, 0, 0, 0, 0, 0, 0), "reset_state");
    rst_n = 1'b1;

    foreach (vecs[i]) run_row(vecs[i], 1'b1, $sformatf("vec%0d", i));

    // Asynchronous reset mid-hold with score 17.
    run_row(mk(0, 0, 0, 1, 0, 0, HighEn ? 99 : 0), 1'b1, "restart_keeps_high");
    repeat (16) begin
      run_row(mk(1, 0, 0, 0, 0, 0, 0), 1'b0, "");
      run_row(mk(1, 0, 0, 0, 0, 0, 0), 1'b0, "");
      run_row(mk(0, 0, 0, 0, 0, 0, 0), 1'b0, "");
      run_row(mk(0, 0, 0, 0, 0, 0, 0), 1'b0, "");
    end
    run_row(mk(1, 0, 0, 0, 0, 0, 0), 1'b0, "");
    run_row(mk(1, 0, 0, 0, 0, 0, 0), 1'b0, "");
    run_row(mk(1, 0, 0, 0, 17, 0, HighEn ? 99 : 0), 1'b1, "score17");
    for (int k = 0; k < 3; k++) begin
      run_row(mk(1, 1, 0, 0, 17, 0, HighEn ? 99 : 0), 1'b1, $sformatf("hold17_%0d", k));
    end
    #2;
    move  = 1'b0;
    tick  = 1'b0;
    rst_n = 1'b0;
    #1;
    check(mk(0, 0, 0, 0, 0, 0, 0), "async_reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    // First press after reset only leaves IDLE; the second one scores.
    run_row(mk(1, 0, 0, 0, 0, 0, 0), 1'b0, "");
    run_row(mk(1, 0, 0, 0, 0, 0, 0), 1'b0, "");
    run_row(mk(0, 0, 0, 0, 0, 0, 0), 1'b1, "idle_first_press");
    run_row(mk(0, 0, 0, 0, 0, 0, 0), 1'b0, "");
    run_row(mk(1, 0, 0, 0, 0, 0, 0), 1'b0, "");
    run_row(mk(1, 0, 0, 0, 0, 0, 0), 1'b0, "");
    run_row(mk(0, 0, 0, 0, 1, 0, 0), 1'b1, "play_after_reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/score_keeper.md
# score_keeper

Produces the 7-bit score consumed by the score renderer and tracks game state for the crossy-road VGA design. The score increments while the player holds the move button, is frozen on collision, and clears on restart. It sits between the synchronized input pins and the score renderer, and also drives BCD digits so that downstream logic needs no divider.

## Interface
- `HOLD_FRAMES`, default 8: frame ticks between auto-increments while move is held; valid range 1..255.
- `MAX_SCORE`, default 99: saturation value; must be ≤ 99.
- `i_clk` input 1: pixel clock.
- `i_rst_n` input 1: reset; one clock, asynchronous assert, active-low.
- `i_frame_tick` input 1: single-cycle pulse, once per frame.
- `i_move` input 1: raw move button, asynchronous to `i_clk`.
- `i_collision` input 1: level; player hit an obstacle.
- `i_restart` input 1: single-cycle pulse; start a new game.
- `o_score` output 7: binary score, 0..MAX_SCORE.
- `o_score_tens` output 4: BCD tens digit.
- `o_score_ones` output 4: BCD ones digit.
- `o_high_score` output 7: best score since reset (present only with the macro; otherwise tied to 0).
- `o_game_over` output 1: high while the state is OVER.

## Operation
- `i_move` passes through a 2-flop synchronizer to give `move_s`.
- A rising edge of `move_s` is detected against a third flop, giving `move_rise`.
- States:
  - IDLE: entered on reset.
  - PLAY
  - OVER
- Transitions:
  - IDLE→PLAY on `move_rise`. No increment occurs on this edge.
  - PLAY→OVER on `i_collision`=1.
  - Any state→PLAY on `i_restart`. This clears the score and the hold counter.
- Scoring applies in PLAY only:
  - `move_rise` gives +1 and clears the hold counter.
  - While `move_s`=1, each `i_frame_tick` increments the hold counter. When the counter reaches HOLD_FRAMES, the score gets +1 and the counter returns to 0.
  - `move_s`=0 clears the hold counter.
- Score saturates at MAX_SCORE. Increments beyond it are dropped, and the BCD outputs hold 9/9.
- The binary score and the BCD pair update together, in the same cycle.
- Priority, highest first: reset > `i_restart` > `i_collision` > increment.
  - Collision and increment in the same cycle: no increment; go to OVER.
  - Restart and collision in the same cycle: PLAY with score 0.
- In OVER the score is frozen, and `i_move`/`i_frame_tick` are ignored.
- In IDLE the score stays 0.

## Timing
- Reset values: `o_score`=0, `o_score_tens`=0, `o_score_ones`=0, `o_high_score`=0, `o_game_over`=0, state=IDLE, hold counter=0.
- All outputs are registered.
- Latency from `i_move` rising to score update is 3 clocks: 2 synchronizer clocks plus 1 edge/update clock.
- `i_frame_tick`, `i_collision` and `i_restart` have 1-clock latency to their outputs.
- `o_game_over` asserts 1 clock after `i_collision` is sampled in PLAY.
- Reset mid-game returns all outputs to their reset values immediately (asynchronously).

## Configuration
- `SCORE_KEEPER_HIGH_SCORE_EN` defined:
  - Adds a high-score register, updated whenever `o_score` > `o_high_score`.
  - The register is cleared only by `i_rst_n`; it survives `i_restart`.
  - It is driven on `o_high_score`.
- Undefined:
  - No high-score register is built.
  - `o_high_score` is constant 0.

## Structure
- Shared package `crossyroad_pkg` holds:
  - The state enum: IDLE=2'd0, PLAY=2'd1, OVER=2'd2.
  - `SCORE_W`=7 and `BCD_W`=4.
- Sub-module `bcd_digit_counter`, instantiated twice (ones, tens):
  - Ports: clear, increment enable, carry out, 4-bit digit.
  - The ones carry feeds the tens increment.
  - Saturation is gated in the parent.

## Test plan
- Reset, then hold `i_move`=1: state goes IDLE→PLAY and score stays 0 for 3 clocks. With HOLD_FRAMES=8, 8 frame ticks give score 1.
- In PLAY, 5 discrete move presses (release between) give `o_score`=5, tens=0, ones=5.
- Preload 98, then press 3 times: `o_score`=99, BCD 9/9. Also check the 9→10 carry: ones=0, tens=1.
- `i_collision` in the same cycle as the 8th frame tick: score unchanged, `o_game_over`=1 next clock, later presses ignored.
- In OVER with score 42, pulse `i_restart`: score 0, `o_game_over`=0, PLAY. With the macro defined, `o_high_score`=42.
- Assert `i_rst_n`=0 mid-hold with score 17: all outputs 0 asynchronously. After release the state is IDLE.
